// File: rtl/rr_mux_select_pkg.sv
// Shared definitions for the round-robin mux select generator.
package rr_mux_select_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_mux_select_pick4.sv
// Rotating-priority picker: the first set request after `last` wins, so `last` itself ranks lowest.
module rr_pick4
  import rr_mux_select_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = NREQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_select.sv
// Round-robin select generator for the 4-to-1 mux: grants a requester for a burst of up to
// HOLD_MAX valid/ready beats, then rotates.
module rr_mux_select
  import rr_mux_select_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            ready,
  output logic            s0,
  output logic            s1,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  localparam logic [3:0] BeatLast = 4'(HOLD_MAX - 1);

  state_e           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic [3:0]       beats_q, beats_d;

  logic             idle_found, next_found;
  logic [IDX_W-1:0] idle_idx, next_idx;
  logic [NREQ-1:0]  req_masked;
  logic             beat, release_now;

  // In GRANT, grant_q is one-hot on the current owner, so this masks exactly that bit.
  assign req_masked = req & ~grant_q;

  rr_pick4 u_pick_idle (
    .req   (req),
    .last  (last_q),
    .found (idle_found),
    .idx   (idle_idx)
  );

  rr_pick4 u_pick_next (
    .req   (req_masked),
    .last  (sel_q),
    .found (next_found),
    .idx   (next_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    valid_d     = valid_q;
    beats_d     = beats_q;
    beat        = valid_q & ready;
    release_now = (beat && (beats_q == BeatLast)) || !req[sel_q];

    case (state_q)
      ST_IDLE: begin
        if (idle_found) begin
          state_d = ST_GRANT;
          grant_d = 4'b0001 << idle_idx;
          sel_d   = idle_idx;
          valid_d = 1'b1;
          beats_d = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          last_d  = sel_q;
          beats_d = '0;
          if (next_found) begin
            grant_d = 4'b0001 << next_idx;
            sel_d   = next_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            sel_d   = '0;
            valid_d = 1'b0;
          end
        end else if (beat) begin
          beats_d = beats_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      beats_q <= beats_d;
    end
  end

  assign s0    = sel_q[0];
  assign s1    = sel_q[1];
  assign grant = grant_q;
  assign valid = valid_q;

endmodule
